// File: rtl/player_pkg.sv
// player_pkg: action codes, FSM states, key decode and x-clamp shared by the player datapath.
package player_pkg;
    localparam logic [9:0] ACT_WALK0  = 10'd0;
    localparam logic [9:0] ACT_IDLE   = 10'd9;
    localparam logic [9:0] ACT_PUNCH1 = 10'd12;
    localparam logic [9:0] ACT_PUNCH2 = 10'd13;
    localparam logic [9:0] ACT_PUNCH3 = 10'd14;
    localparam logic [9:0] ACT_PUNCH4 = 10'd11;
    localparam logic [9:0] ACT_JUMP   = 10'd15;
    localparam logic [7:0] KEY_LEFT_DEF  = 8'h6b;
    localparam logic [7:0] KEY_RIGHT_DEF = 8'h74;
    localparam logic [7:0] KEY_PUNCH_DEF = 8'h70;
    localparam logic [7:0] KEY_JUMP_DEF  = 8'h75;
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_PUNCH, S_JUMP} state_t;
    typedef enum logic [2:0] {K_NONE, K_LEFT, K_RIGHT, K_PUNCH, K_JUMP} key_t;
    function automatic logic [9:0] clamp_x(input logic signed [10:0] v,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
        return v < lo ? lo[9:0] : (v > hi ? hi[9:0] : v[9:0]);
    endfunction
endpackage

// File: rtl/player_ctrl_edge_tick.sv
// edge_tick: registered rising-edge detector producing a one-Clk-wide tick pulse.
module edge_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic tick
);
    logic sig_q, sig_d, tick_q, tick_d;
    always_comb begin
        sig_d  = sig;
        tick_d = sig & ~sig_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sig_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            tick_q <= tick_d;
        end
    end
    assign tick = tick_q;
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: per-player movement/animation FSM stepped once per frame tick.
module player_ctrl
    import player_pkg::*;
#(
    parameter int         START_X     = 320,
    parameter int         GROUND_Y    = 400,
    parameter int         X_MIN       = 1,
    parameter int         X_MAX       = 579,
    parameter int         STEP_X      = 5,
    parameter int         WIDTH       = 60,
    parameter int         HEIGHT      = 70,
    parameter int         WALK_FRAMES = 8,
    parameter int         WALK_HOLD   = 3,
    parameter int         PUNCH_HOLD  = 5,
    parameter int         JUMP_V      = 12,
    parameter int         GRAVITY     = 1,
    parameter logic [7:0] KEY_LEFT    = KEY_LEFT_DEF,
    parameter logic [7:0] KEY_RIGHT   = KEY_RIGHT_DEF,
    parameter logic [7:0] KEY_PUNCH   = KEY_PUNCH_DEF,
    parameter logic [7:0] KEY_JUMP    = KEY_JUMP_DEF,
    parameter logic       DIR_INIT    = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       press,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic [9:0] action,
    output logic       direction,
    output logic       punch_active,
    output logic       is_player
);
    state_t            state_q, state_d;
    logic [9:0]        px_q, px_d, py_q, py_d, action_q, action_d;
    logic signed [7:0] vy_q, vy_d;
    logic [7:0]        cnt_q, cnt_d, frame_q, frame_d;
    logic              dir_q, dir_d, punch_q, punch_d;
    logic              tick, horiz, land;
    key_t              key;
    logic signed [10:0] x_mv, y_sum;
    logic [9:0]        x_new;

    edge_tick u_tick (.Clk(Clk), .Reset(Reset), .sig(frame_clk), .tick(tick));

    always_comb begin
        key   = !press ? K_NONE :
                keycode == KEY_PUNCH ? K_PUNCH :
                keycode == KEY_JUMP  ? K_JUMP  :
                keycode == KEY_LEFT  ? K_LEFT  :
                keycode == KEY_RIGHT ? K_RIGHT : K_NONE;
        horiz = key == K_LEFT || key == K_RIGHT;
        x_mv  = key == K_LEFT ? $signed({1'b0, px_q}) - $signed(11'(STEP_X))
                              : $signed({1'b0, px_q}) + $signed(11'(STEP_X));
        x_new = clamp_x(x_mv, 11'(X_MIN), 11'(X_MAX));
        y_sum = $signed({1'b0, py_q}) + $signed({{3{vy_q[7]}}, vy_q});
        land  = y_sum >= $signed(11'(GROUND_Y));
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        vy_d     = vy_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        action_d = action_q;
        dir_d    = dir_q;
        if (tick) begin
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (key == K_PUNCH) begin
                        state_d  = S_PUNCH;
                        action_d = ACT_PUNCH1;
                        cnt_d    = 8'd0;
                    end else if (key == K_JUMP) begin
                        state_d  = S_JUMP;
                        vy_d     = 8'(-JUMP_V);
                        action_d = ACT_JUMP;
                    end else if (horiz) begin
                        state_d = S_WALK;
                        px_d    = x_new;
                        dir_d   = key == K_RIGHT;
                        if (state_q == S_IDLE) begin
                            frame_d = 8'd0;
                            cnt_d   = 8'd0;
                        end else if (cnt_q == 8'(WALK_HOLD - 1)) begin
                            cnt_d   = 8'd0;
                            frame_d = frame_q == 8'(WALK_FRAMES - 1) ? 8'd0 : frame_q + 8'd1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        action_d = {2'b00, frame_d};
                    end else begin
                        state_d  = S_IDLE;
                        action_d = ACT_IDLE;
                        cnt_d    = 8'd0;
                    end
                end
                // committed sequence: keys are ignored until the last phase expires
                S_PUNCH: begin
                    if (cnt_q == 8'(PUNCH_HOLD - 1)) begin
                        cnt_d    = 8'd0;
                        state_d  = action_q == ACT_PUNCH4 ? S_IDLE : S_PUNCH;
                        action_d = action_q == ACT_PUNCH1 ? ACT_PUNCH2 :
                                   action_q == ACT_PUNCH2 ? ACT_PUNCH3 :
                                   action_q == ACT_PUNCH3 ? ACT_PUNCH4 : ACT_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_JUMP: begin
                    if (horiz) begin
                        px_d  = x_new;
                        dir_d = key == K_RIGHT;
                    end
                    if (land) begin
                        py_d     = 10'(GROUND_Y);
                        vy_d     = 8'sd0;
                        state_d  = S_IDLE;
                        action_d = ACT_IDLE;
                    end else begin
                        py_d = y_sum[9:0];
                        vy_d = vy_q + 8'(GRAVITY);
                    end
                end
            endcase
        end
        punch_d = action_d == ACT_PUNCH3;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            px_q     <= 10'(START_X);
            py_q     <= 10'(GROUND_Y);
            vy_q     <= 8'sd0;
            cnt_q    <= 8'd0;
            frame_q  <= 8'd0;
            action_q <= ACT_IDLE;
            dir_q    <= DIR_INIT;
            punch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            vy_q     <= vy_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            action_q <= action_d;
            dir_q    <= dir_d;
            punch_q  <= punch_d;
        end
    end

    assign px           = px_q;
    assign py           = py_q;
    assign action       = action_q;
    assign direction    = dir_q;
    assign punch_active = punch_q;
    assign is_player = {1'b0, DrawX} >= {1'b0, px_q} && {1'b0, DrawX} <= {1'b0, px_q} + 11'(WIDTH - 1) &&
                       {1'b0, DrawY} >= {1'b0, py_q} && {1'b0, DrawY} <= {1'b0, py_q} + 11'(HEIGHT - 1);
endmodule
